// File: rtl/csa_reduce_seq_if.sv
// rtl/csa_reduce_seq_if.sv - handshake bundle for the sequential carry-save reduction stage
//
// Purpose: groups the partial-product input handshake and the product output
// handshake of csa_reduce_seq into one port.
// Signals:
//   in_valid  pp valid (master -> slave)
//   in_ready  stage can accept pp (slave -> master)
//   pp        WIDTH rows of 2*WIDTH bits, row 0 at the LSBs (master -> slave)
//   out_valid product valid (slave -> master)
//   out_ready consumer accepts product (master -> slave)
//   product   sum of all rows mod 2^(2*WIDTH) (slave -> master)
//   busy      stage is not idle (slave -> master)
interface csa_reduce_seq_if #(
   parameter int WIDTH = 32
);
   localparam int PW = 2 * WIDTH;

   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH*PW-1:0]   pp;
   logic                  out_valid;
   logic                  out_ready;
   logic [PW-1:0]         product;
   logic                  busy;

   modport master (
      output in_valid, pp, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, pp, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/csa_reduce_seq.sv
// rtl/csa_reduce_seq.sv - sequential carry-save reduction of a partial-product matrix
//
// Purpose: latches WIDTH partial-product rows, folds PP_PER_CYCLE rows per clock
// into a (sum, carry) pair with chained 3:2 compressors, then resolves the pair
// with one carry-propagate add and holds the product until it is accepted.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of csa_reduce_seq_if (in_valid/in_ready/pp, out_valid/out_ready/product, busy)
module csa_reduce_seq #(
   parameter int WIDTH        = 32,
   parameter int PP_PER_CYCLE = 2
) (
   input  logic           clk,
   input  logic           rst,
   csa_reduce_seq_if.slave bus
);
   localparam int PW    = 2 * WIDTH;
   localparam int NGRP  = WIDTH / PP_PER_CYCLE;
   localparam int CW    = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam int RW    = $clog2(WIDTH);
   localparam int SHIFT = $clog2(PP_PER_CYCLE);
   localparam logic [CW-1:0] LAST = CW'(NGRP - 1);

   typedef enum logic [1:0] {
      IDLE,
      REDUCE,
      FINAL,
      DONE
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [PW-1:0]   rows [WIDTH];
   logic [PW-1:0]   s_acc;
   logic [PW-1:0]   c_acc;
   logic [PW-1:0]   s_fold;
   logic [PW-1:0]   c_fold;
   logic [PW-1:0]   s_new;
   logic [PW-1:0]   row;
   logic [PW-1:0]   maj;
   logic [RW-1:0]   idx;
   logic [PW-1:0]   prod_reg;
   logic [CW-1:0]   cnt;
   logic            valid_reg;
   logic            accept;
   logic            out_take;

   assign accept   = (state == IDLE) && bus.in_valid;
   assign out_take = (state == DONE) && valid_reg && bus.out_ready;

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = valid_reg;
   assign bus.product   = prod_reg;

   // Chain of PP_PER_CYCLE compressors: each row of the current group is folded
   // into the running pair in ascending row order. The carry vector is the
   // majority shifted up one bit, with the top carry dropped (mod 2^PW).
   always_comb begin
      s_fold = s_acc;
      c_fold = c_acc;
      s_new  = '0;
      row    = '0;
      maj    = '0;
      idx    = '0;
      for (int j = 0; j < PP_PER_CYCLE; j++) begin
         idx    = (RW'(cnt) << SHIFT) + RW'(j);
         row    = rows[idx];
         maj    = (s_fold & c_fold) | (s_fold & row) | (c_fold & row);
         s_new  = s_fold ^ c_fold ^ row;
         c_fold = {maj[PW-2:0], 1'b0};
         s_fold = s_new;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = REDUCE;
         REDUCE:  if (cnt == LAST) state_next = FINAL;
         FINAL:   state_next = DONE;
         DONE:    if (out_take) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_acc     <= '0;
         c_acc     <= '0;
         prod_reg  <= '0;
         cnt       <= '0;
         valid_reg <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            rows[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  for (int i = 0; i < WIDTH; i++) begin
                     rows[i] <= bus.pp[i*PW +: PW];
                  end
                  s_acc <= '0;
                  c_acc <= '0;
                  cnt   <= '0;
               end
            end
            REDUCE: begin
               s_acc <= s_fold;
               c_acc <= c_fold;
               cnt   <= cnt + CW'(1);
            end
            FINAL: begin
               prod_reg  <= s_acc + c_acc;
               valid_reg <= 1'b1;
            end
            DONE: begin
               if (out_take) valid_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule
